// File: rtl/radix4_booth_pkg.sv
// Shared types and width helpers for the radix-4 Booth sequential MAC.
package radix4_booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ACC  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_P1   = 3'd1,
    DIG_P2   = 3'd2,
    DIG_M1   = 3'd3,
    DIG_M2   = 3'd4
  } digit_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ACC_W = 24;

  // Two guard bits cover the 2X digit of the most negative multiplicand.
  function automatic int ppWidth(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int digitCount(input int w);
    return w / 2;
  endfunction

  function automatic digit_t decodeWindow(input logic [2:0] win);
    case (win)
      3'b001, 3'b010: return DIG_P1;
      3'b011:         return DIG_P2;
      3'b100:         return DIG_M2;
      3'b101, 3'b110: return DIG_M1;
      default:        return DIG_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/radix4_booth_enc.sv
// Radix-4 Booth digit encoder: one 3-bit multiplier window and the
// multiplicand in, sign-extended partial product out.
module radix4_booth_enc
  import radix4_booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic        [2:0]              i_win,
  input  logic signed [WIDTH-1:0]        i_x,
  output logic signed [ppWidth(WIDTH)-1:0] o_pp
);

  localparam int PP_W = ppWidth(WIDTH);

  logic signed [PP_W-1:0] w_xExt;

  assign w_xExt = PP_W'(i_x);

  always_comb begin
    o_pp = '0;
    case (decodeWindow(i_win))
      DIG_P1:  o_pp = w_xExt;
      DIG_P2:  o_pp = w_xExt <<< 1;
      DIG_M1:  o_pp = -w_xExt;
      DIG_M2:  o_pp = -(w_xExt <<< 1);
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mac.sv
// Sequential signed radix-4 Booth multiply-accumulate, one digit per clock.
// Define MACC_SAT_EN for a saturating accumulator with sticky o_ovf.
module booth_r4_seq_mac
  import radix4_booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic                    i_acc_clr,
  output logic                    o_valid,
  output logic signed [2*WIDTH-1:0] o_mul,
  output logic signed [ACC_W-1:0] o_acc,
  output logic                    o_ovf
);

  localparam int PP_W = ppWidth(WIDTH);
  localparam int NDIG = digitCount(WIDTH);
  localparam int K_W  = $clog2(NDIG) + 1;
  localparam logic [K_W-1:0] LAST_K = K_W'(NDIG - 1);

  state_t r_state;
  state_t w_nextState;

  logic signed [WIDTH-1:0]   r_x;
  logic        [WIDTH:0]     r_y;
  logic                      r_clr;
  logic signed [PP_W-1:0]    r_partial;
  logic        [K_W-1:0]     r_k;

  logic        [2:0]         w_win;
  logic signed [PP_W-1:0]    w_pp;
  logic signed [2*WIDTH-1:0] w_mul;
  logic signed [ACC_W-1:0]   w_mulExt;
  logic signed [ACC_W-1:0]   w_accNext;
  logic                      w_load;
  logic                      w_step;
  logic                      w_done;

  // r_y carries the implicit y[-1]=0 in bit 0, so digit k reads bits 2k+2..2k.
  assign w_win    = 3'(r_y >> {r_k, 1'b0});
  assign w_mul    = (2*WIDTH)'(r_partial);
  assign w_mulExt = ACC_W'(w_mul);

  radix4_booth_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .i_win (w_win),
    .i_x   (r_x),
    .o_pp  (w_pp)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (i_valid) w_nextState = ST_RUN;
      ST_RUN:  if (r_k == LAST_K) w_nextState = ST_ACC;
      ST_ACC:  w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready = (r_state == ST_IDLE);
    w_load  = (r_state == ST_IDLE) && i_valid;
    w_step  = (r_state == ST_RUN);
    w_done  = (r_state == ST_ACC);
  end

`ifdef MACC_SAT_EN
  logic signed [ACC_W:0] w_sum;
  logic                  w_clamp;
  logic                  r_ovf;

  // One extra bit exposes signed overflow as a disagreement of the top two bits.
  assign w_sum   = (ACC_W+1)'(o_acc) + (ACC_W+1)'(w_mul);
  assign w_clamp = !r_clr && (w_sum[ACC_W] != w_sum[ACC_W-1]);

  always_comb begin
    w_accNext = w_sum[ACC_W-1:0];
    if (r_clr)          w_accNext = w_mulExt;
    else if (w_clamp)   w_accNext = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                 : {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst)                r_ovf <= 1'b0;
    else if (w_done) begin
      if (r_clr)            r_ovf <= 1'b0;
      else if (w_clamp)     r_ovf <= 1'b1;
    end
  end

  assign o_ovf = r_ovf;
`else
  assign w_accNext = r_clr ? w_mulExt : o_acc + w_mulExt;
  assign o_ovf     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_clr     <= 1'b0;
      r_partial <= '0;
      r_k       <= '0;
      o_valid   <= 1'b0;
      o_mul     <= '0;
      o_acc     <= '0;
    end else begin
      o_valid <= w_done;
      if (w_load) begin
        r_x       <= x;
        r_y       <= {y, 1'b0};
        r_clr     <= i_acc_clr;
        r_partial <= '0;
        r_k       <= '0;
      end
      if (w_step) begin
        r_partial <= r_partial + (w_pp <<< {r_k, 1'b0});
        r_k       <= r_k + 1'b1;
      end
      if (w_done) begin
        o_mul <= w_mul;
        o_acc <= w_accNext;
      end
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mac.sv
// Self-checking bench for booth_r4_seq_mac: arithmetic reference model with
// per-cycle compare, plus hand-computed directed vectors (honours MACC_SAT_EN).
module tb_booth_r4_seq_mac;

  localparam int  W     = 8;
  localparam int  ACC   = 24;
  localparam int  LAT   = W / 2 + 1;
  localparam longint MOD  = longint'(1) <<< ACC;
  localparam longint HALF = longint'(1) <<< (ACC - 1);

  logic                  clk;
  logic                  rst;
  logic                  iValid;
  logic                  oReady;
  logic signed [W-1:0]   x;
  logic signed [W-1:0]   y;
  logic                  accClr;
  logic                  oValid;
  logic signed [2*W-1:0] oMul;
  logic signed [ACC-1:0] oAcc;
  logic                  oOvf;

  logic                  v16;
  logic                  ready16;
  logic                  valid16;
  logic signed [2*W-1:0] mul16;
  logic signed [15:0]    acc16;
  logic                  ovf16;

  booth_r4_seq_mac #(.WIDTH(W), .ACC_W(ACC)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (iValid),
    .o_ready   (oReady),
    .x         (x),
    .y         (y),
    .i_acc_clr (accClr),
    .o_valid   (oValid),
    .o_mul     (oMul),
    .o_acc     (oAcc),
    .o_ovf     (oOvf)
  );

  booth_r4_seq_mac #(.WIDTH(W), .ACC_W(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (v16),
    .o_ready   (ready16),
    .x         (x),
    .y         (y),
    .i_acc_clr (accClr),
    .o_valid   (valid16),
    .o_mul     (mul16),
    .o_acc     (acc16),
    .o_ovf     (ovf16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    longint mul;
    longint acc;
    bit     ovf;
    int     due;
  } exp_t;

  exp_t   exps[$];
  int     cyc      = 0;
  int     rstCount = 0;
  int     flushTo  = 0;
  longint mAcc     = 0;
  bit     mOvf     = 1'b0;

  int     errors = 0;
  int     checks = 0;
  bit     cmpOn  = 1'b0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: sees every accepted pair and records what its completion must show.
  always @(posedge clk) begin
    longint mul;
    longint s;
    cyc = cyc + 1;
    if (rst) begin
      rstCount = rstCount + 1;
      flushTo  = exps.size();
      mAcc     = 0;
      mOvf     = 1'b0;
    end else if (iValid && oReady) begin
      mul = longint'(x) * longint'(y);
      if (accClr) begin
        mAcc = mul;
        mOvf = 1'b0;
      end else begin
        s = mAcc + mul;
`ifdef MACC_SAT_EN
        if (s > HALF - 1) begin s = HALF - 1; mOvf = 1'b1; end
        if (s < -HALF)    begin s = -HALF;    mOvf = 1'b1; end
`else
        s = s & (MOD - 1);
        if (s >= HALF) s = s - MOD;
`endif
        mAcc = s;
      end
      exps.push_back('{mul, mAcc, mOvf, cyc + LAT});
    end
  end

  int     rdPtr   = 0;
  int     lastRst = 0;
  longint showMul = 0;
  longint showAcc = 0;
  bit     showOvf = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rstCount != lastRst) begin
      lastRst = rstCount;
      rdPtr   = flushTo;
      showMul = 0;
      showAcc = 0;
      showOvf = 1'b0;
    end
    if (cmpOn) begin
      if (oValid) begin
        if (rdPtr >= exps.size()) begin
          checkOutput("unexpected o_valid", 1, 0);
        end else begin
          e       = exps[rdPtr];
          rdPtr   = rdPtr + 1;
          showMul = e.mul;
          showAcc = e.acc;
          showOvf = e.ovf;
          checkOutput("latency", longint'(cyc), longint'(e.due));
          checkOutput("o_ready with o_valid", longint'(oReady), 1);
        end
      end
      checkOutput("o_mul", longint'(oMul), showMul);
      checkOutput("o_acc", longint'(oAcc), showAcc);
      checkOutput("o_ovf", longint'(oOvf), longint'(showOvf));
    end
  end

  task automatic applyStimulus(input logic signed [W-1:0] xv, input logic signed [W-1:0] yv,
                               input logic clr, input bit sat);
    bit got;
    got = 1'b0;
    @(negedge clk);
    x      = xv;
    y      = yv;
    accClr = clr;
    if (sat) v16 = 1'b1;
    else     iValid = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      got = sat ? ready16 : oReady;
    end
    if (!got) checkOutput("accept timeout", 0, 1);
  endtask

  task automatic waitResult(input bit sat, output longint m, output longint a, output longint ov);
    bit got;
    got = 1'b0;
    m = 0; a = 0; ov = 0;
    @(negedge clk);
    iValid = 1'b0;
    v16    = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (sat ? valid16 : oValid) begin
        got = 1'b1;
        m   = sat ? longint'(mul16) : longint'(oMul);
        a   = sat ? longint'(acc16) : longint'(oAcc);
        ov  = sat ? longint'(ovf16) : longint'(oOvf);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) checkOutput("result timeout", 0, 1);
  endtask

  initial begin
    longint m, a, ov;
    rst    = 1'b1;
    iValid = 1'b0;
    v16    = 1'b0;
    x      = '0;
    y      = '0;
    accClr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset o_ready", longint'(oReady), 1);
    checkOutput("reset o_valid", longint'(oValid), 0);
    checkOutput("reset o_mul",   longint'(oMul),   0);
    checkOutput("reset o_acc",   longint'(oAcc),   0);
    checkOutput("reset o_ovf",   longint'(oOvf),   0);
    rst   = 1'b0;
    cmpOn = 1'b1;

    applyStimulus(8'sd1, 8'sd1, 1'b1, 1'b0);
    waitResult(1'b0, m, a, ov);
    checkOutput("1*1 mul", m, 1);
    checkOutput("1*1 acc", a, 1);

    applyStimulus(-8'sd128, -8'sd128, 1'b1, 1'b0);
    waitResult(1'b0, m, a, ov);
    checkOutput("-128*-128 mul", m, 16384);
    checkOutput("-128*-128 acc", a, 16384);
    applyStimulus(8'sd127, -8'sd128, 1'b0, 1'b0);
    waitResult(1'b0, m, a, ov);
    checkOutput("127*-128 mul", m, -16256);
    checkOutput("127*-128 acc", a, 128);

    // Reset lands two digits into the pair; that pair must never complete.
    applyStimulus(8'sd5, 8'sd7, 1'b0, 1'b0);
    @(negedge clk);
    iValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-run reset o_ready", longint'(oReady), 1);
    checkOutput("mid-run reset o_valid", longint'(oValid), 0);
    checkOutput("mid-run reset o_acc",   longint'(oAcc),   0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    applyStimulus(8'sd3, 8'sd4, 1'b1, 1'b0);
    @(negedge clk);
    x      = 8'sd100;
    y      = 8'sd100;
    accClr = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
    waitResult(1'b0, m, a, ov);
    checkOutput("3*4 mul", m, 12);
    checkOutput("3*4 acc", a, 12);
    applyStimulus(-8'sd7, 8'sd9, 1'b0, 1'b0);
    waitResult(1'b0, m, a, ov);
    checkOutput("-7*9 mul", m, -63);
    checkOutput("-7*9 acc", a, -51);

    applyStimulus(8'sd127, 8'sd127, 1'b1, 1'b1);
    waitResult(1'b1, m, a, ov);
    applyStimulus(8'sd127, 8'sd127, 1'b0, 1'b1);
    waitResult(1'b1, m, a, ov);
    applyStimulus(8'sd127, 8'sd127, 1'b0, 1'b1);
    waitResult(1'b1, m, a, ov);
    checkOutput("acc16 mul", m, 16129);
`ifdef MACC_SAT_EN
    checkOutput("acc16 sat acc", a, 32767);
    checkOutput("acc16 sat ovf", ov, 1);
`else
    checkOutput("acc16 wrap acc", a, -17149);
    checkOutput("acc16 wrap ovf", ov, 0);
`endif

    for (int i = 0; i < 2000; i++) begin
      applyStimulus(W'($urandom), W'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
    end
    @(negedge clk);
    iValid = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("pairs completed", longint'(rdPtr), longint'(exps.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
